// File: rtl/ahb5_pkg.sv
// Shared AHB5 bus types and slave state encoding.
package ahb5_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'd0,
    HT_BUSY   = 2'd1,
    HT_NONSEQ = 2'd2,
    HT_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    SZ_BYTE  = 3'd0,
    SZ_HALF  = 3'd1,
    SZ_WORD  = 3'd2,
    SZ_DWORD = 3'd3,
    SZ_4W    = 3'd4,
    SZ_8W    = 3'd5,
    SZ_16W   = 3'd6,
    SZ_32W   = 3'd7
  } hsize_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slv_state_t;

endpackage

// File: rtl/ahb5_byte_lane_decode.sv
// Byte-enable and size/alignment check for one AHB address phase.
module ahb5_byte_lane_decode #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [$clog2(DATA_WIDTH/8)-1:0] addr_lo,
  input  logic [2:0]                      size,
  output logic [DATA_WIDTH/8-1:0]         byte_en,
  output logic                            err
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int LW = $clog2(NB);

  always_comb begin
    int nbytes;
    nbytes  = 32'd1 << size;
    byte_en = '0;
    err     = 1'b0;
    if (int'(size) > LW) begin
      err = 1'b1;
    end else begin
      err = (int'(addr_lo) & (nbytes - 1)) != 0;
      for (int i = 0; i < NB; i++) begin
        byte_en[i] = (i >= int'(addr_lo)) &&
                     (i < int'(addr_lo) + nbytes);
      end
    end
  end

endmodule

// File: rtl/ahb5_slave_mem.sv
// AHB5 memory slave with wait states, two-cycle ERROR and write strobes.
module ahb5_slave_mem
  import ahb5_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    MEM_DEPTH   = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0,
  parameter int                    WSTRB_EN    = 0
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    HSEL,
  input  logic [ADDR_WIDTH-1:0]   HADDR,
  input  logic [1:0]              HTRANS,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [2:0]              HBURST,
  input  logic [DATA_WIDTH-1:0]   HWDATA,
  input  logic [DATA_WIDTH/8-1:0] HWSTRB,
  input  logic                    HREADY,
  output logic [DATA_WIDTH-1:0]   HRDATA,
  output logic                    HREADYOUT,
  output logic                    HRESP
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int LW = $clog2(NB);
  localparam int IW = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] HI =
    LO + (ADDR_WIDTH+1)'(MEM_DEPTH * NB);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  slv_state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic wr_q;
  logic [IW-1:0] idx_q;
  logic [NB-1:0] be_q;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [NB-1:0] be, lane_en;
  logic [ADDR_WIDTH-1:0] off;
  logic lane_err, range_err, legal;
  logic accept, done, last, wen;
  logic unused_ok;

  ahb5_byte_lane_decode #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_lane (
    .addr_lo(HADDR[LW-1:0]),
    .size   (HSIZE),
    .byte_en(be),
    .err    (lane_err)
  );

  assign range_err = ({1'b0, HADDR} < LO) ||
                     ({1'b0, HADDR} >= HI);
  assign legal  = ~range_err & ~lane_err;
  assign accept = HSEL & HREADY & HTRANS[1];
  assign off    = (HADDR - BASE_ADDR) >> LW;
  assign last   = (state == ST_DATA) && (cnt == 4'd0);
  // Any cycle with HREADYOUT high ends a data phase and may take an address.
  assign done   = last || (state == ST_IDLE) || (state == ST_ERR2);

  assign unused_ok = ^{HBURST, HTRANS[0], off};

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      ST_ERR1: state_n = ST_ERR2;
      ST_DATA: if (cnt != 4'd0) cnt_n = cnt - 4'd1;
      default: ;
    endcase
    if (done) begin
      state_n = ST_IDLE;
      cnt_n   = 4'd0;
      if (accept) begin
        state_n = legal ? ST_DATA : ST_ERR1;
        cnt_n   = legal ? WS : 4'd0;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
      wr_q  <= 1'b0;
      idx_q <= '0;
      be_q  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (done && accept && legal) begin
        wr_q  <= HWRITE;
        idx_q <= off[IW-1:0];
        be_q  <= be;
      end
    end
  end

  assign wen     = last && wr_q;
  assign lane_en = be_q & ((WSTRB_EN != 0) ? HWSTRB : '1);

  // Array is deliberately not reset; contents survive HRESETn.
  always_ff @(posedge HCLK) begin
    if (wen) begin
      for (int b = 0; b < NB; b++) begin
        if (lane_en[b]) mem[idx_q][b*8 +: 8] <= HWDATA[b*8 +: 8];
      end
    end
  end

  assign HRDATA    = (last && !wr_q) ? mem[idx_q] : '0;
  assign HREADYOUT = (state == ST_DATA) ? (cnt == 4'd0) :
                     (state != ST_ERR1);
  assign HRESP     = (state == ST_ERR1 || state == ST_ERR2) ?
                     HRESP_ERROR : HRESP_OKAY;

endmodule

// File: tb/tb_ahb5_slave_mem.sv
// Directed bench for ahb5_slave_mem against a transaction-level model.
module tb_ahb5_slave_mem;
  import ahb5_pkg::*;

  localparam int DEPTH = 256;
  localparam logic [31:0] BASE_B = 32'h400;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } xfer_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] haddr = '0;
  logic [31:0] hwdata = '0;
  logic [1:0]  htrans = '0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = '0;
  logic [2:0]  hburst = '0;
  logic [3:0]  hwstrb = '0;
  logic        sel_a = 1'b0;
  logic        sel_b = 1'b0;
  logic [31:0] rdata_a, rdata_b;
  logic        ready_a, ready_b, resp_a, resp_b;

  int dut = 0;
  logic [31:0] rdata;
  logic ready, resp;
  assign rdata = (dut != 0) ? rdata_b : rdata_a;
  assign ready = (dut != 0) ? ready_b : ready_a;
  assign resp  = (dut != 0) ? resp_b  : resp_a;

  ahb5_slave_mem #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(DEPTH),
    .BASE_ADDR(32'h0), .WAIT_STATES(0), .WSTRB_EN(0)
  ) u_a (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(sel_a), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize),
    .HBURST(hburst), .HWDATA(hwdata), .HWSTRB(hwstrb),
    .HREADY(ready_a), .HRDATA(rdata_a), .HREADYOUT(ready_a),
    .HRESP(resp_a)
  );

  ahb5_slave_mem #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(DEPTH),
    .BASE_ADDR(BASE_B), .WAIT_STATES(3), .WSTRB_EN(1)
  ) u_b (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(sel_b), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize),
    .HBURST(hburst), .HWDATA(hwdata), .HWSTRB(hwstrb),
    .HREADY(ready_b), .HRDATA(rdata_b), .HREADYOUT(ready_b),
    .HRESP(resp_b)
  );

  int n_chk = 0;
  int n_fail = 0;
  int ph_cyc = 0;
  int busy_cyc = 0;
  int low_cyc = 0;
  int err_cyc = 0;
  logic [31:0] last_rd = '0;
  xfer_t dq[$];
  logic [31:0] mm [int];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit illegal(int d, logic [31:0] a, logic [2:0] s);
    longint base, nb;
    base = (d != 0) ? BASE_B : 0;
    nb = longint'(1) << s;
    return (a < base) || (a >= base + DEPTH * 4) ||
           (nb > 4) || ((a % nb) != 0);
  endfunction

  function automatic int key(int d, logic [31:0] a);
    logic [31:0] base;
    base = (d != 0) ? BASE_B : 32'h0;
    return d * 4096 + int'((a - base) >> 2);
  endfunction

  function automatic void model_write(int d, xfer_t t);
    int k;
    logic [31:0] w;
    longint ba;
    k = key(d, t.addr);
    w = mm.exists(k) ? mm[k] : 32'h0;
    for (int b = 0; b < 4; b++) begin
      ba = longint'(t.addr & 32'hFFFF_FFFC) + b;
      if (ba >= t.addr && ba < t.addr + (longint'(1) << t.size) &&
          (d == 0 || t.strb[b]))
        w[b*8 +: 8] = t.wdata[b*8 +: 8];
    end
    mm[k] = w;
  endfunction

  xfer_t cur;
  logic e_ready, e_resp, ck_rd, er;
  logic [31:0] e_rd;
  int ws, k;

  // Each accepted transfer owns WAIT_STATES+1 (OKAY) or 2 (ERROR) cycles.
  always @(negedge clk) begin
    if (rst_n) begin
      ws = (dut != 0) ? 3 : 0;
      e_ready = 1'b1;
      e_resp = 1'b0;
      e_rd = '0;
      ck_rd = 1'b1;
      er = 1'b0;
      if (!ready) low_cyc++;
      if (resp) err_cyc++;
      if (dq.size() > 0) begin
        cur = dq[0];
        busy_cyc++;
        er = illegal(dut, cur.addr, cur.size);
        if (er) begin
          e_resp = 1'b1;
          e_ready = (ph_cyc == 1);
        end else begin
          e_ready = (ph_cyc == ws);
          if (cur.write) ck_rd = 1'b0;
          else if (e_ready) begin
            k = key(dut, cur.addr);
            e_rd = mm.exists(k) ? mm[k] : 32'hx;
          end
        end
      end
      chk("hreadyout", {31'b0, ready}, {31'b0, e_ready});
      chk("hresp", {31'b0, resp}, {31'b0, e_resp});
      if (ck_rd) chk("hrdata", rdata, e_rd);
      if (dq.size() > 0) begin
        if (e_ready) begin
          if (!er && cur.write) model_write(dut, cur);
          if (!er && !cur.write) last_rd = rdata;
          void'(dq.pop_front());
          ph_cyc = 0;
        end else begin
          ph_cyc++;
        end
      end
    end
  end

  task automatic issue(logic [31:0] a, logic w, logic [2:0] s,
                       logic [31:0] wd, logic [3:0] st,
                       logic [1:0] tr, logic [2:0] hb);
    xfer_t t;
    logic r;
    int n;
    n = 0;
    haddr = a; hwrite = w; hsize = s; htrans = tr; hburst = hb;
    do begin
      @(negedge clk);
      r = ready;
      @(posedge clk);
      n++;
    end while (!r && n < 40);
    chk("accept_timeout", {31'b0, r}, 32'd1);
    #1;
    t = '{a, w, s, wd, st};
    dq.push_back(t);
    hwdata = wd;
    hwstrb = st;
    htrans = HT_IDLE;
  endtask

  task automatic wr(logic [31:0] a, logic [2:0] s, logic [31:0] d,
                    logic [3:0] st);
    issue(a, 1'b1, s, d, st, HT_NONSEQ, 3'b000);
  endtask

  task automatic rd(logic [31:0] a);
    issue(a, 1'b0, SZ_WORD, 32'h0, 4'h0, HT_NONSEQ, 3'b000);
  endtask

  task automatic idle_bus();
    int n;
    n = 0;
    htrans = HT_IDLE;
    while (dq.size() > 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_timeout", dq.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready_a", {31'b0, ready_a}, 32'd1);
    chk("rst_resp_a", {31'b0, resp_a}, 32'd0);
    chk("rst_rdata_a", rdata_a, 32'd0);
    chk("rst_ready_b", {31'b0, ready_b}, 32'd1);
    chk("rst_resp_b", {31'b0, resp_b}, 32'd0);
    chk("rst_rdata_b", rdata_b, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    dut = 0;
    sel_a = 1'b1;
    wr(32'h10, SZ_WORD, 32'hDEADBEEF, 4'hF);
    low_cyc = 0;
    rd(32'h10);
    idle_bus();
    chk("b2b_rdata", last_rd, 32'hDEADBEEF);
    chk("b2b_no_wait", low_cyc, 32'd0);

    wr(32'h10, SZ_WORD, 32'h11223344, 4'hF);
    wr(32'h13, SZ_BYTE, 32'hAA000000, 4'h8);
    rd(32'h10);
    idle_bus();
    chk("byte_merge", last_rd, 32'hAA223344);

    err_cyc = 0;
    wr(32'h11, SZ_HALF, 32'h00FFFF00, 4'hF);
    rd(32'h10);
    idle_bus();
    chk("misalign_err_cycles", err_cyc, 32'd2);
    chk("misalign_unchanged", last_rd, 32'hAA223344);

    wr(32'h20, SZ_WORD, 32'h01020304, 4'hF);
    wr(32'h22, SZ_HALF, 32'hBEEF0000, 4'hC);
    issue(32'h20, 1'b1, SZ_DWORD, 32'h0, 4'hF, HT_NONSEQ, 3'b000);
    rd(32'h20);
    idle_bus();
    chk("half_write", last_rd, 32'hBEEF0304);

    err_cyc = 0;
    wr(32'h400, SZ_WORD, 32'h55555555, 4'hF);
    rd(32'h10);
    idle_bus();
    chk("range_err_cycles", err_cyc, 32'd2);
    chk("read_after_err", last_rd, 32'hAA223344);

    htrans = HT_BUSY;
    repeat (2) @(posedge clk);
    #1;
    htrans = HT_IDLE;
    sel_a = 1'b0;
    @(posedge clk);
    #1;

    dut = 1;
    sel_b = 1'b1;
    wr(32'h400, SZ_WORD, 32'h12345678, 4'hF);
    idle_bus();
    low_cyc = 0;
    rd(32'h400);
    idle_bus();
    chk("ws3_low_cycles", low_cyc, 32'd3);
    chk("ws3_rdata", last_rd, 32'h12345678);

    busy_cyc = 0;
    for (int i = 0; i < 4; i++)
      issue(32'h410 + 32'(4 * i), 1'b1, SZ_WORD, 32'hA0 + 32'(i), 4'hF,
            (i == 0) ? HT_NONSEQ : HT_SEQ, 3'b011);
    idle_bus();
    chk("incr4_cycles", busy_cyc, 32'd16);
    for (int i = 0; i < 4; i++)
      issue(32'h410 + 32'(4 * i), 1'b0, SZ_WORD, 32'h0, 4'h0,
            (i == 0) ? HT_NONSEQ : HT_SEQ, 3'b011);
    idle_bus();
    chk("incr4_last", last_rd, 32'hA3);

    wr(32'h420, SZ_WORD, 32'h0, 4'hF);
    wr(32'h420, SZ_WORD, 32'hFFFFFFFF, 4'b0101);
    rd(32'h420);
    idle_bus();
    chk("wstrb", last_rd, 32'h00FF00FF);

    err_cyc = 0;
    rd(32'h3FC);
    idle_bus();
    chk("below_base_err", err_cyc, 32'd2);

    wr(32'h400, SZ_WORD, 32'hCAFEF00D, 4'hF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {31'b0, ready_b}, 32'd1);
    chk("mid_rst_resp", {31'b0, resp_b}, 32'd0);
    chk("mid_rst_rdata", rdata_b, 32'd0);
    dq.delete();
    ph_cyc = 0;
    htrans = HT_IDLE;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd(32'h400);
    idle_bus();
    chk("reset_discard", last_rd, 32'h12345678);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
